// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the 16-bit execute-stage ALU.
package alu_pkg;

   localparam int WIDTH = 16;
   localparam int NFLAGS = 5;

   // Major opcodes (Opcode[7:4])
   localparam logic [3:0] MAJ_REG   = 4'h0;
   localparam logic [3:0] OP_ADDI   = 4'h5;
   localparam logic [3:0] OP_ADDUI  = 4'h6;
   localparam logic [3:0] OP_ADDCI  = 4'h7;
   localparam logic [3:0] OP_SHIFT  = 4'h8;

   // Minor opcodes (Opcode[3:0]) under MAJ_REG
   localparam logic [3:0] OP_AND    = 4'h1;
   localparam logic [3:0] OP_OR     = 4'h2;
   localparam logic [3:0] OP_XOR    = 4'h3;
   localparam logic [3:0] OP_NOT    = 4'h4;
   localparam logic [3:0] OP_ADD    = 4'h5;
   localparam logic [3:0] OP_ADDU   = 4'h6;
   localparam logic [3:0] OP_ADDC   = 4'h7;
   localparam logic [3:0] OP_ADDCU  = 4'h8;
   localparam logic [3:0] OP_SUB    = 4'h9;
   localparam logic [3:0] OP_CMP    = 4'hB;
   localparam logic [3:0] OP_CMPU   = 4'hF;

   // Minor opcodes under OP_SHIFT; LSHI is accepted with either encoding
   localparam logic [3:0] SH_LSHI     = 4'h0;
   localparam logic [3:0] SH_LSHI_ALT = 4'h1;
   localparam logic [3:0] SH_LSH      = 4'h4;

   localparam int FLAG_Z = 4;
   localparam int FLAG_C = 3;
   localparam int FLAG_O = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_L = 0;

endpackage

// File: rtl/alu_add16.sv
// 16-bit adder with carry-in and carry-out, shared by every add/sub flavour of the ALU.
module alu_add16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};

endmodule

// File: rtl/alu.sv
// 16-bit ALU: combinational opcode decode around one shared adder, one registered output stage.
module alu
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic [7:0]        Opcode,
   input  logic              Cin,
   output logic [WIDTH-1:0]  C,
   output logic [NFLAGS-1:0] Flags
);

   logic [3:0]        major;
   logic [3:0]        minor;
   logic [WIDTH-1:0]  imm;
   logic [WIDTH-1:0]  add_b;
   logic              add_cin;
   logic [WIDTH-1:0]  sum;
   logic              cout;
   logic [WIDTH-1:0]  res_d;
   logic [NFLAGS-1:0] flg_d;
   logic              z_en;

   assign major = Opcode[7:4];
   assign minor = Opcode[3:0];
   assign imm   = {8'h00, Opcode};

   // Adder operand steering: subtraction is A + ~B + 1, immediates replace B.
   // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      add_b   = B;
      add_cin = 1'b0;
      case (major)
         MAJ_REG: begin
            if (minor == OP_ADDC || minor == OP_ADDCU) begin
               add_cin = Cin;
            end else if (minor == OP_SUB) begin
               add_b   = ~B;
               add_cin = 1'b1;
            end
         end
         OP_ADDI, OP_ADDUI: add_b = imm;
         OP_ADDCI: begin
            add_b   = imm;
            add_cin = Cin;
         end
         default: ;
      endcase
   end

   alu_add16 u_add (
      .a    (A),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
      res_d = '0;
      flg_d = '0;
      z_en  = 1'b0;
      case (major)
         MAJ_REG: begin
            case (minor)
               OP_AND: begin res_d = A & B; z_en = 1'b1; end
               OP_OR:  begin res_d = A | B; z_en = 1'b1; end
               OP_XOR: begin res_d = A ^ B; z_en = 1'b1; end
               OP_NOT: begin res_d = ~A;    z_en = 1'b1; end
               OP_ADD, OP_ADDC: begin
                  res_d         = sum;
                  z_en          = 1'b1;
                  flg_d[FLAG_C] = cout;
                  flg_d[FLAG_O] = (~A[15] & ~B[15] & sum[15]) | (A[15] & B[15] & ~sum[15]);
               end
               OP_ADDU, OP_ADDCU: begin
                  res_d         = sum;
                  z_en          = 1'b1;
                  flg_d[FLAG_C] = cout;
                  flg_d[FLAG_O] = (A[15] | B[15]) & ~sum[15];
               end
               OP_SUB: begin
                  // Borrow is not reported; carry stays clear for SUB.
                  res_d         = sum;
                  z_en          = 1'b1;
                  flg_d[FLAG_O] = (~A[15] & B[15] & sum[15]) | (A[15] & ~B[15] & ~sum[15]);
               end
               OP_CMP: begin
                  flg_d[FLAG_Z] = (A == B);
                  flg_d[FLAG_N] = ($signed(A) < $signed(B));
                  flg_d[FLAG_L] = ($signed(A) < $signed(B));
               end
               OP_CMPU: begin
                  flg_d[FLAG_Z] = (A == B);
                  flg_d[FLAG_L] = (A < B);
               end
               default: ;
            endcase
         end
         OP_ADDI, OP_ADDCI: begin
            res_d         = sum;
            z_en          = 1'b1;
            flg_d[FLAG_C] = cout;
            flg_d[FLAG_O] = ~A[15] & sum[15];
         end
         OP_ADDUI: begin
            res_d         = sum;
            z_en          = 1'b1;
            flg_d[FLAG_C] = cout;
            flg_d[FLAG_O] = A[15] & ~sum[15];
         end
         OP_SHIFT: begin
            case (minor)
               SH_LSHI, SH_LSHI_ALT: begin res_d = A << B[3:0]; z_en = 1'b1; end
               SH_LSH:               begin res_d = A << 1;      z_en = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
      // Reserved codes leave z_en clear so their flags stay all-zero.
      if (z_en) begin
         flg_d[FLAG_Z] = (res_d == '0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         C     <= '0;
         Flags <= '0;
      end else begin
         C     <= res_d;
         Flags <= flg_d;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal vectors plus a per-cycle comparison against a behavioural model.
module tb_alu;

   logic        clk;
   logic        reset;
   logic [15:0] A;
   logic [15:0] B;
   logic [7:0]  Opcode;
   logic        Cin;
   logic [15:0] C;
   logic [4:0]  Flags;

   int n_checks = 0;
   int n_fail   = 0;
   logic        chk_en = 1'b0;
   logic [15:0] exp_c;
   logic [4:0]  exp_f;

   alu dut (
      .clk    (clk),
      .reset  (reset),
      .A      (A),
      .B      (B),
      .Opcode (Opcode),
      .Cin    (Cin),
      .C      (C),
      .Flags  (Flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Behavioural model: flags from plain integer arithmetic and range tests.
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                                 input logic cin, output logic [15:0] c, output logic [4:0] f);
      int ua, ub, sa, sb, imm, s, sv;
      logic zv;
      ua  = int'(a);
      ub  = int'(b);
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      imm = int'(op);
      c   = 16'h0000;
      f   = 5'b00000;
      zv  = 1'b0;
      case (op[7:4])
         4'h0: begin
            case (op[3:0])
               4'h1: begin c = a & b; zv = 1'b1; end
               4'h2: begin c = a | b; zv = 1'b1; end
               4'h3: begin c = a ^ b; zv = 1'b1; end
               4'h4: begin c = ~a;    zv = 1'b1; end
               4'h5, 4'h7: begin
                  s  = ua + ub + ((op[3:0] == 4'h7) ? int'(cin) : 0);
                  sv = sa + sb + ((op[3:0] == 4'h7) ? int'(cin) : 0);
                  c  = s[15:0];
                  f[3] = (s > 65535);
                  f[2] = (sv > 32767) || (sv < -32768);
                  zv = 1'b1;
               end
               4'h6, 4'h8: begin
                  s  = ua + ub + ((op[3:0] == 4'h8) ? int'(cin) : 0);
                  c  = s[15:0];
                  f[3] = (s > 65535);
                  f[2] = (a[15] | b[15]) & ~c[15];
                  zv = 1'b1;
               end
               4'h9: begin
                  s  = ua - ub;
                  sv = sa - sb;
                  c  = s[15:0];
                  f[2] = (sv > 32767) || (sv < -32768);
                  zv = 1'b1;
               end
               4'hB: begin
                  f[4] = (a == b);
                  f[1] = (sa < sb);
                  f[0] = (sa < sb);
               end
               4'hF: begin
                  f[4] = (a == b);
                  f[0] = (ua < ub);
               end
               default: ;
            endcase
         end
         4'h5, 4'h7: begin
            s  = ua + imm + ((op[7:4] == 4'h7) ? int'(cin) : 0);
            sv = sa + imm + ((op[7:4] == 4'h7) ? int'(cin) : 0);
            c  = s[15:0];
            f[3] = (s > 65535);
            f[2] = (sv > 32767);
            zv = 1'b1;
         end
         4'h6: begin
            s  = ua + imm;
            c  = s[15:0];
            f[3] = (s > 65535);
            f[2] = a[15] & ~c[15];
            zv = 1'b1;
         end
         4'h8: begin
            if (op[3:0] == 4'h0 || op[3:0] == 4'h1) begin
               s = ua * (1 << int'(b[3:0]));
               c = s[15:0];
               zv = 1'b1;
            end else if (op[3:0] == 4'h4) begin
               s = ua * 2;
               c = s[15:0];
               zv = 1'b1;
            end
         end
         default: ;
      endcase
      if (zv) f[4] = (c == 16'h0000);
   endfunction

   // Expected outputs one clock after the inputs.
   always @(posedge clk) begin
      logic [15:0] mc;
      logic [4:0]  mf;
      model(A, B, Opcode, Cin, mc, mf);
      if (reset) begin
         exp_c <= 16'h0000;
         exp_f <= 5'b00000;
      end else begin
         exp_c <= mc;
         exp_f <= mf;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_c", C, exp_c);
         check("model_flags", {11'h000, Flags}, {11'h000, exp_f});
      end
   end

   // Called at posedge+1; applies a vector and checks the registered result one edge later.
   task automatic run(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] op, input logic cin,
                      input logic [15:0] ec, input logic [4:0] ef);
      A = a; B = b; Opcode = op; Cin = cin;
      @(posedge clk);
      #1;
      check({name, "_c"}, C, ec);
      check({name, "_flags"}, {11'h000, Flags}, {11'h000, ef});
   endtask

   initial begin
      reset = 1'b1; A = 16'd5; B = 16'd3; Opcode = 8'h05; Cin = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("reset_c", C, 16'h0000);
      check("reset_flags", {11'h000, Flags}, 16'h0000);
      reset = 1'b0;

      run("add_ovf",    16'h7FFF, 16'h0001, 8'h05, 1'b0, 16'h8000, 5'b00100);
      run("add_carry",  16'hFFFF, 16'h0001, 8'h05, 1'b0, 16'h0000, 5'b11000);
      run("sub_neg",    16'd3,    16'd5,    8'h09, 1'b0, 16'hFFFE, 5'b00000);
      run("cmp_lt",     16'd3,    16'd5,    8'h0B, 1'b0, 16'h0000, 5'b00011);
      run("cmp_eq",     16'd7,    16'd7,    8'h0B, 1'b0, 16'h0000, 5'b10000);
      run("cmpu_gt",    16'hFFFF, 16'h0001, 8'h0F, 1'b0, 16'h0000, 5'b00000);
      run("cmpu_lt",    16'h0001, 16'hFFFF, 8'h0F, 1'b0, 16'h0000, 5'b00001);
      run("addc",       16'd10,   16'd20,   8'h07, 1'b1, 16'd31,   5'b00000);
      run("addi",       16'h0010, 16'h1234, 8'h5A, 1'b0, 16'h006A, 5'b00000);
      run("and_zero",   16'h00F0, 16'h0F00, 8'h01, 1'b0, 16'h0000, 5'b10000);
      run("lshi",       16'h8001, 16'd4,    8'h80, 1'b0, 16'h0010, 5'b00000);
      run("lshi_alt",   16'h8001, 16'h0013, 8'h81, 1'b0, 16'h0008, 5'b00000);
      run("lsh",        16'h8001, 16'd4,    8'h84, 1'b0, 16'h0002, 5'b00000);
      run("resv_e3",    16'h8001, 16'd4,    8'hE3, 1'b0, 16'h0000, 5'b00000);
      run("resv_0a",    16'h0000, 16'h0000, 8'h0A, 1'b0, 16'h0000, 5'b00000);
      run("addu_wrap",  16'h8000, 16'h8000, 8'h06, 1'b0, 16'h0000, 5'b11100);
      run("not_ffff",   16'hFFFF, 16'h1234, 8'h04, 1'b0, 16'h0000, 5'b10000);
      run("addci_cy",   16'hFFFF, 16'h0000, 8'h7F, 1'b1, 16'h007F, 5'b01000);
      run("addui",      16'h8000, 16'h0000, 8'h60, 1'b0, 16'h8060, 5'b00000);

      for (int i = 0; i < 10000; i++) begin
         A      = 16'($urandom);
         B      = ($urandom_range(0, 7) == 0) ? A : 16'($urandom);
         Opcode = 8'($urandom);
         Cin    = 1'($urandom);
         @(posedge clk);
         #1;
      end

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
